// File: rtl/motion_pkg.sv
// Shared types and constants for the motion-detection front end.
// Optional coring of the gradient stage is enabled with `define SOBEL_CORING_EN.
package motion_pkg;

    localparam int DEF_PIX_W      = 8;
    localparam int GRAD_W         = 16;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DONE,
        OVERRUN
    } state_e;

    // Sobel kernel weights: outer taps and centre tap of each 3-tap column/row
    localparam int SOBEL_W_EDGE   = 1;
    localparam int SOBEL_W_CENTRE = 2;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: combinational read and synchronous write at the same
// address, so a read in the write cycle returns the previous line's sample.
module sobel_line_buffer
    import motion_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int WIDTH = DEF_PIX_W,
    parameter int AW    = $clog2(DEF_IMG_WIDTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_gradient_stage.sv
// Raster luma -> |Gx|+|Gy| Sobel magnitude for interior pixels, two-cycle latency.
// `define SOBEL_CORING_EN zeroes magnitudes below CORE_LEVEL in the final stage.
module sobel_gradient_stage
    import motion_pkg::*;
#(
    parameter int              IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int              IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int              PIX_W      = DEF_PIX_W,
    parameter logic [GRAD_W-1:0] CORE_LEVEL = 16'd32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic [GRAD_W-1:0] current_gradient,
    output logic              valid_pixel,
    output logic              frame_start,
    output logic              frame_err
);

    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int G_W = PIX_W + 3;

    function automatic logic signed [G_W-1:0] sobel_axis(
        input logic [PIX_W-1:0] a0, a1, a2, b0, b1, b2
    );
        int sa;
        int sb;
        sa = SOBEL_W_EDGE * int'(a0) + SOBEL_W_CENTRE * int'(a1) + SOBEL_W_EDGE * int'(a2);
        sb = SOBEL_W_EDGE * int'(b0) + SOBEL_W_CENTRE * int'(b1) + SOBEL_W_EDGE * int'(b2);
        return G_W'(sb - sa);
    endfunction

    function automatic logic [G_W-1:0] abs_val(input logic signed [G_W-1:0] v);
        return v[G_W-1] ? G_W'(-v) : v;
    endfunction

    function automatic logic [G_W-1:0] core_mag(input logic [G_W-1:0] m);
`ifdef SOBEL_CORING_EN
        return (GRAD_W'(m) < CORE_LEVEL) ? '0 : m;
`else
        return m;
`endif
    endfunction

`ifndef SOBEL_CORING_EN
    logic unused_core;
    assign unused_core = ^CORE_LEVEL;
`endif

    state_e         state, state_nxt;
    logic [CW-1:0]  col, col_nxt, acc_col;
    logic [RW-1:0]  row, row_nxt, acc_row;
    logic           accept, qualify, err_nxt;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    logic [PIX_W-1:0]        win_p0 [3][3];
    logic                    vld_p0, sof_p0;
    logic signed [G_W-1:0]   gx_p1, gy_p1;
    logic                    vld_p1, sof_p1;
    logic [G_W-1:0]          mag_p1;

    // A sof pixel always lands at (0,0), whatever the counters hold
    always_comb begin
        acc_col   = pix_sof ? '0 : col;
        acc_row   = pix_sof ? '0 : row;
        accept    = pix_valid && (pix_sof || state == ACTIVE);
        qualify   = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        err_nxt   = 1'b0;
        if (pix_valid) begin
            if (pix_sof) begin
                err_nxt   = (state == ACTIVE);
                state_nxt = ACTIVE;
            end else if (state == DONE) begin
                err_nxt   = 1'b1;
                state_nxt = OVERRUN;
            end
            if (accept) begin
                if (acc_col == CW'(IMG_WIDTH - 1)) begin
                    col_nxt = '0;
                    row_nxt = acc_row;
                    if (acc_row == RW'(IMG_HEIGHT - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        row_nxt = acc_row + RW'(1);
                    end
                end else begin
                    col_nxt = acc_col + CW'(1);
                    row_nxt = acc_row;
                end
            end
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (acc_col),
        .wr_data (pix_in),
        .rd_data (lb1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
        .clk     (clk),
        .we      (accept),
        .addr    (acc_col),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SOF;
            col         <= '0;
            row         <= '0;
            frame_err   <= 1'b0;
            vld_p0      <= 1'b0;
            sof_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            sof_p1      <= 1'b0;
            valid_pixel <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            frame_err   <= err_nxt;
            vld_p0      <= qualify;
            sof_p0      <= pix_valid && pix_sof;
            vld_p1      <= vld_p0;
            sof_p1      <= sof_p0;
            valid_pixel <= vld_p1;
            frame_start <= sof_p1;
        end
    end

    // Stage 0: window shift, newest column enters at index 2 (row 0 = oldest line)
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_p0[r][0] <= win_p0[r][1];
                win_p0[r][1] <= win_p0[r][2];
            end
            win_p0[0][2] <= lb2_rd;
            win_p0[1][2] <= lb1_rd;
            win_p0[2][2] <= pix_in;
        end
    end

    // Stage 1: signed directional gradients
    always_ff @(posedge clk) begin
        gx_p1 <= sobel_axis(win_p0[0][0], win_p0[1][0], win_p0[2][0],
                            win_p0[0][2], win_p0[1][2], win_p0[2][2]);
        gy_p1 <= sobel_axis(win_p0[0][0], win_p0[0][1], win_p0[0][2],
                            win_p0[2][0], win_p0[2][1], win_p0[2][2]);
    end

    assign mag_p1 = abs_val(gx_p1) + abs_val(gy_p1);

    // Stage 2: magnitude, held between valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_gradient <= '0;
        end else if (vld_p1) begin
            current_gradient <= GRAD_W'(core_mag(mag_p1));
        end
    end

endmodule

// File: tb/tb_sobel_gradient_stage.sv
// Directed bench for sobel_gradient_stage on an 8x6 frame; expected gradients
// follow from the hand-computed edge/step patterns below.
module tb_sobel_gradient_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic [15:0] current_gradient;
    logic        valid_pixel;
    logic        frame_start;
    logic        frame_err;

    sobel_gradient_stage #(
        .IMG_WIDTH  (8),
        .IMG_HEIGHT (6),
        .PIX_W      (8),
        .CORE_LEVEL (16'd32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pix_in           (pix_in),
        .pix_valid        (pix_valid),
        .pix_sof          (pix_sof),
        .current_gradient (current_gradient),
        .valid_pixel      (valid_pixel),
        .frame_start      (frame_start),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0, n_fs = 0, n_ferr = 0;
    int fs_cyc = -1, ferr_cyc = -1;
    int last_n, sof_n, p49_n;
    int b_out, b_fs, b_ferr;
    int          exp_lat [$];
    logic [15:0] exp_val [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pattern kinds: 0 flat 100, 1 edge 0/255, 2 step 50/56, 3 step 50/60 (split after col 3)
    function automatic logic [7:0] pix_of(input int kind, input int x);
        case (kind)
            0:       return 8'd100;
            1:       return (x < 4) ? 8'd0  : 8'd255;
            2:       return (x < 4) ? 8'd50 : 8'd56;
            default: return (x < 4) ? 8'd50 : 8'd60;
        endcase
    endfunction

    // Only centre columns 3 and 4 straddle the step: 4 * step height
    function automatic logic [15:0] exp_of(input int kind, input int cx);
        logic [15:0] amp;
        case (kind)
            0: amp = 16'd0;
            1: amp = 16'd1020;
`ifdef SOBEL_CORING_EN
            2: amp = 16'd0;
`else
            2: amp = 16'd24;
`endif
            default: amp = 16'd40;
        endcase
        return (cx == 3 || cx == 4) ? amp : 16'd0;
    endfunction

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drive(input logic [7:0] p, input logic sof, input logic qual, input logic [15:0] ev);
        @(negedge clk);
        pix_in    = p;
        pix_valid = 1'b1;
        pix_sof   = sof;
        last_n    = cyc + 1;
        if (qual) begin
            exp_lat.push_back(last_n + 2);
            exp_val.push_back(ev);
        end
    endtask

    task automatic send_frame(input int kind, input bit bub, input int npix, input bit with_sof);
        for (int i = 0; i < npix; i++) begin
            int x;
            int y;
            x = i % 8;
            y = i / 8;
            if (bub) repeat ($urandom_range(1, 0)) idle();
            drive(pix_of(kind, x), with_sof && (i == 0), (x >= 2 && y >= 2 && y < 6), exp_of(kind, x - 1));
            if (i == 0)  sof_n = last_n;
            if (i == 48) p49_n = last_n;
        end
        idle();
    endtask

    task automatic mark();
        b_out  = n_out;
        b_fs   = n_fs;
        b_ferr = n_ferr;
    endtask

    task automatic frame_checks(input string tag, input int outs, input int fss, input int errs);
        repeat (5) idle();
        check_val({tag, "_nout"}, n_out - b_out, outs);
        check_val({tag, "_pend"}, exp_val.size(), 0);
        check_val({tag, "_nfs"}, n_fs - b_fs, fss);
        check_val({tag, "_fs_lat"}, fs_cyc, sof_n + 2);
        check_val({tag, "_nerr"}, n_ferr - b_ferr, errs);
    endtask

    // Output monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (valid_pixel) begin
                n_out++;
                check_val("fs_overlap", frame_start, 0);
                if (exp_val.size() == 0) begin
                    check_val("unexp_out", valid_pixel, 0);
                end else begin
                    check_val("grad", current_gradient, exp_val.pop_front());
                    check_val("lat", cyc, exp_lat.pop_front());
                end
            end
            if (frame_start) begin
                n_fs++;
                fs_cyc = cyc;
            end
            if (frame_err) begin
                n_ferr++;
                ferr_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_vld", valid_pixel, 0);
        check_val("rst_fs", frame_start, 0);
        check_val("rst_err", frame_err, 0);
        check_val("rst_grad", current_gradient, 0);
        rst_n = 1'b1;
        repeat (2) idle();

        // 1: flat frame
        mark(); send_frame(0, 0, 48, 1); frame_checks("t1", 24, 1, 0);
        // 2: vertical edge
        mark(); send_frame(1, 0, 48, 1); frame_checks("t2", 24, 1, 0);
        // 3: edge with random bubbles
        mark(); send_frame(1, 1, 48, 1); frame_checks("t3", 24, 1, 0);

        // 4: truncated frame, restarted after 20 pixels
        mark();
        send_frame(0, 0, 20, 1);
        send_frame(1, 0, 48, 1);
        frame_checks("t4", 26, 2, 1);
        check_val("t4_err_cyc", ferr_cyc, sof_n);

        // 5a: overrun by two pixels
        mark(); send_frame(1, 0, 50, 1); frame_checks("t5", 24, 1, 1);
        check_val("t5_err_cyc", ferr_cyc, p49_n);

        // 5b: reset while outputs are in flight
        for (int i = 0; i <= 30; i++) begin
            drive(pix_of(1, i % 8), i == 0, ((i % 8) >= 2 && (i / 8) >= 2), exp_of(1, (i % 8) - 1));
        end
        @(posedge clk); #1;
        check_val("pre_rst_vld", valid_pixel, 1);
        check_val("pre_rst_grad", current_gradient, 1020);
        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        #1;
        check_val("mid_rst_vld", valid_pixel, 0);
        check_val("mid_rst_grad", current_gradient, 0);
        check_val("mid_rst_fs", frame_start, 0);
        check_val("mid_rst_err", frame_err, 0);
        exp_val.delete();
        exp_lat.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mark();
        for (int i = 0; i < 12; i++) drive(pix_of(1, i % 8), 1'b0, 1'b0, 16'd0);
        repeat (5) idle();
        check_val("post_rst_nout", n_out - b_out, 0);
        check_val("post_rst_nfs", n_fs - b_fs, 0);
        mark(); send_frame(1, 0, 48, 1); frame_checks("t5r", 24, 1, 0);

        // 6: small steps around the coring floor
        mark(); send_frame(2, 0, 48, 1); frame_checks("t6a", 24, 1, 0);
        mark(); send_frame(3, 0, 48, 1); frame_checks("t6b", 24, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
